// File: rtl/sel_arbiter_pkg.sv
// sel_arbiter_pkg: shared types and constants for the two-channel selector
// arbiter.
//   state_t      arbiter state (IDLE: nothing presented, PRESENT: word held)
//   SEL_B/SEL_C  encoding of the downstream 2:1 select line
//   WIDTH_DEF    default data width
//   DEPTH_DEF    default per-channel FIFO depth
package sel_arbiter_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   localparam logic SEL_B = 1'b1;
   localparam logic SEL_C = 1'b0;

   localparam int unsigned WIDTH_DEF = 8;
   localparam int unsigned DEPTH_DEF = 2;

endpackage

// File: rtl/sel_fifo.sv
// sel_fifo: DEPTH-entry synchronous FIFO (DEPTH a power of two, >= 2).
//   clk, rst_n  clock, asynchronous active-low reset
//   push, din   write request and data; ignored while full
//   pop         read request; ignored while empty
//   full, empty occupancy flags (combinational from the count)
//   ready       registered "not full", held low during reset and for the
//               first edge after it
//   head        oldest stored word
module sel_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic             ready,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned     AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_next;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_comb begin
      count_next = count;
      if (do_push && !do_pop) begin
         count_next = count + 1'b1;
      end else if (do_pop && !do_push) begin
         count_next = count - 1'b1;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ready  <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
         ready <= (count_next != FULL_CNT);
      end
   end

   // Storage needs no reset: head is only consumed while non-empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sel_arbiter.sv
// sel_arbiter: two buffered channels (B, C) arbitrated round-robin onto the
// operand/select inputs of a downstream 2:1 selector.
//   clk, rst_n                      clock, asynchronous active-low reset
//   b_valid/b_ready/b_data          channel B push interface
//   c_valid/c_ready/c_data          channel C push interface
//   sel                             1 = B operand, 0 = C operand
//   b_out, c_out                    operands; the non-granted one holds
//   out_valid/out_ready             result handshake to the consumer
module sel_arbiter
   import sel_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [WIDTH-1:0] b_data,
   input  logic             c_valid,
   output logic             c_ready,
   input  logic [WIDTH-1:0] c_data,
   output logic             sel,
   output logic [WIDTH-1:0] b_out,
   output logic [WIDTH-1:0] c_out,
   output logic             out_valid,
   input  logic             out_ready
);

   state_t           state;
   logic             last;
   logic             b_push, b_pop, b_full, b_empty;
   logic             c_push, c_pop, c_full, c_empty;
   logic [WIDTH-1:0] b_head, c_head;
   logic             load;
   logic             any;
   logic             last_eff;
   logic             grant_b;

   assign b_push = b_valid && b_ready && !b_full;
   assign c_push = c_valid && c_ready && !c_full;

   sel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (b_push),
      .din   (b_data),
      .pop   (b_pop),
      .full  (b_full),
      .empty (b_empty),
      .ready (b_ready),
      .head  (b_head)
   );

   sel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_c (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (c_push),
      .din   (c_data),
      .pop   (c_pop),
      .full  (c_full),
      .empty (c_empty),
      .ready (c_ready),
      .head  (c_head)
   );

   // A new grant may load when idle or when the presented word is being
   // accepted. In the accepting case the word leaving now counts as the
   // last grant, so use sel directly rather than the not-yet-updated last.
   always_comb begin
      load     = (state == IDLE) || out_ready;
      any      = !b_empty || !c_empty;
      last_eff = (state == PRESENT) ? sel : last;
      grant_b  = !b_empty && (c_empty || (last_eff == SEL_C));
      b_pop    = load && any && grant_b;
      c_pop    = load && any && !grant_b;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         sel       <= SEL_C;
         b_out     <= '0;
         c_out     <= '0;
         last      <= SEL_C;
      end else begin
         if (state == PRESENT && out_ready) begin
            last <= sel;
         end
         if (load) begin
            if (any) begin
               state     <= PRESENT;
               out_valid <= 1'b1;
               if (grant_b) begin
                  sel   <= SEL_B;
                  b_out <= b_head;
               end else begin
                  sel   <= SEL_C;
                  c_out <= c_head;
               end
            end else begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule
